// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants and helpers for the pipelined lookahead adder
package cla_pkg;

    localparam int GROUP = 4;

    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } alu_op_e;

    function automatic int cla_lat(input int width, input int slice);
        return width / slice;
    endfunction

endpackage

// File: rtl/cla_adder_pipe_if.sv
// rtl/cla_adder_pipe_if.sv - operand/result handshake bundle for cla_adder_pipe
interface cla_adder_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf, zero
    );
endinterface

// File: rtl/cla_group4.sv
// rtl/cla_group4.sv - 4-bit carry-lookahead group
module cla_group4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_in);
    assign c_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & c_in);

    assign s = p ^ c;
endmodule

// File: rtl/cla_slice.sv
// rtl/cla_slice.sv - combinational SLICE-bit adder built from chained 4-bit lookahead groups
module cla_slice
    import cla_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             c_in,
    output logic [SLICE-1:0] s,
    output logic             c_out,
    output logic             c_msb
);
    localparam int NG = SLICE / GROUP;

    logic [NG:0] c;

    assign c[0] = c_in;

    for (genvar g = 0; g < NG; g++) begin : g_group
        cla_group4 u_group (
            .a    (a[g*GROUP +: GROUP]),
            .b    (b[g*GROUP +: GROUP]),
            .c_in (c[g]),
            .s    (s[g*GROUP +: GROUP]),
            .c_out(c[g+1])
        );
    end

    assign c_out = c[NG];
    // s = a ^ b ^ carry, so the carry into the top bit falls out of the sum bit
    assign c_msb = a[SLICE-1] ^ b[SLICE-1] ^ s[SLICE-1];
endmodule

// File: rtl/cla_adder_pipe.sv
// rtl/cla_adder_pipe.sv - pipelined carry-lookahead add/sub, one SLICE per stage, valid/ready handshake
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    cla_adder_pipe_if.slave bus
);
    localparam int LAT = cla_lat(WIDTH, SLICE);
    localparam int SKW = (LAT > 1) ? LAT - 1 : 1;

    logic en;

    // slot k is what stage k works on; slot 0 is the live input beat
    logic [WIDTH-1:0] in_a  [LAT];
    logic [WIDTH-1:0] in_b  [LAT];
    logic [WIDTH-1:0] in_p  [LAT];
    logic             in_c  [LAT];
    logic             in_v  [LAT];
    logic [SLICE-1:0] s_w   [LAT];
    logic             co_w  [LAT];
    logic             cm_w  [LAT];
    logic [WIDTH-1:0] nxt_p [LAT];

    // register k holds the result of stage k-1; register LAT is the output
    logic             vld_q  [1:LAT];
    logic             cy_q   [1:LAT];
    logic             ovf_q  [1:LAT];
    logic [WIDTH-1:0] part_q [1:LAT];
    logic [WIDTH-1:0] op_a_q [1:SKW];
    logic [WIDTH-1:0] op_b_q [1:SKW];
    logic             zero_q;

    assign en            = !vld_q[LAT] || bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = vld_q[LAT];
    assign bus.sum       = part_q[LAT];
    assign bus.c_out     = cy_q[LAT];
    assign bus.ovf       = ovf_q[LAT];
    assign bus.zero      = zero_q;

    always_comb begin
        in_a[0] = bus.a;
        in_b[0] = bus.sub ? ~bus.b : bus.b;
        in_p[0] = '0;
        in_c[0] = bus.sub;
        in_v[0] = bus.in_valid;
        for (int j = 1; j < LAT; j++) begin
            in_a[j] = op_a_q[j];
            in_b[j] = op_b_q[j];
            in_p[j] = part_q[j];
            in_c[j] = cy_q[j];
            in_v[j] = vld_q[j];
        end
    end

    for (genvar k = 0; k < LAT; k++) begin : g_stage
        cla_slice #(
            .SLICE(SLICE)
        ) u_slice (
            .a    (in_a[k][k*SLICE +: SLICE]),
            .b    (in_b[k][k*SLICE +: SLICE]),
            .c_in (in_c[k]),
            .s    (s_w[k]),
            .c_out(co_w[k]),
            .c_msb(cm_w[k])
        );
    end

    always_comb begin
        for (int k = 0; k < LAT; k++) begin
            nxt_p[k]                   = in_p[k];
            nxt_p[k][k*SLICE +: SLICE] = s_w[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= LAT; k++) begin
                vld_q[k]  <= 1'b0;
                cy_q[k]   <= 1'b0;
                ovf_q[k]  <= 1'b0;
                part_q[k] <= '0;
            end
            for (int k = 1; k <= SKW; k++) begin
                op_a_q[k] <= '0;
                op_b_q[k] <= '0;
            end
            zero_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < LAT; k++) begin
                vld_q[k+1]  <= in_v[k];
                part_q[k+1] <= nxt_p[k];
                cy_q[k+1]   <= co_w[k];
                ovf_q[k+1]  <= co_w[k] ^ cm_w[k];
            end
            // operands ride along so later stages see the same beat's upper bits
            for (int k = 0; k < LAT - 1; k++) begin
                op_a_q[k+1] <= in_a[k];
                op_b_q[k+1] <= in_b[k];
            end
            zero_q <= (nxt_p[LAT-1] == '0);
        end
    end
endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb/tb_cla_adder_pipe.sv - scoreboard bench for cla_adder_pipe (WIDTH=32, SLICE=8)
module tb_cla_adder_pipe;
    import cla_pkg::*;

    typedef struct packed {
        logic [31:0] sum;
        logic        c;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n_pop = 0;
    bit   mon_en = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    cla_adder_pipe_if #(.WIDTH(32)) bus ();

    cla_adder_pipe #(
        .WIDTH(32),
        .SLICE(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time_limit reached expected finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [32:0] full;
        logic [31:0] bb;
        exp_t        e;
        bb     = s ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {32'd0, s};
        e.sum  = full[31:0];
        e.c    = full[32];
        e.ovf  = (a[31] == bb[31]) && (full[31] != a[31]);
        e.zero = (full[31:0] == 32'd0);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            checks++;
            if (bus.in_ready !== !(bus.out_valid && !bus.out_ready)) begin
                errors++;
                $display("FAIL handshake in_ready=%b expected=%b", bus.in_ready,
                         !(bus.out_valid && !bus.out_ready));
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                n_pop++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output sum=%h expected no output", bus.sum);
                end else begin
                    mon_e = sb.pop_front();
                    if ({bus.sum, bus.c_out, bus.ovf, bus.zero} !== mon_e) begin
                        errors++;
                        $display("FAIL result got sum=%h c=%b ovf=%b zero=%b expected sum=%h c=%b ovf=%b zero=%b",
                                 bus.sum, bus.c_out, bus.ovf, bus.zero,
                                 mon_e.sum, mon_e.c, mon_e.ovf, mon_e.zero);
                    end
                end
            end
        end
    end

    task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic s,
                             input exp_t e, output int waited);
        bit done;
        done   = 1'b0;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.sub      = s;
        while (!done && waited < 200) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            waited++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout a=%h accepted=0 expected=1", a);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending=%0d expected 0", tag, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got=%b expected=0", bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b expected=1", bus.in_ready);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL idle_handshake got out_valid,in_ready=%b expected=01",
                     {bus.out_valid, bus.in_ready});
        end
        checks++;
        if (bus.sum !== 32'd0) begin
            errors++;
            $display("FAIL idle_sum got=%h expected=0", bus.sum);
        end
        checks++;
        if ({bus.c_out, bus.ovf, bus.zero} !== 3'b000) begin
            errors++;
            $display("FAIL idle_flags got c,ovf,zero=%b expected=000",
                     {bus.c_out, bus.ovf, bus.zero});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_carry_ripple();
        exp_t e;
        e = '{sum: 32'h0, c: 1'b1, ovf: 1'b0, zero: 1'b1};
        bus.in_valid = 1'b1;
        bus.a        = 32'hFFFF_FFFF;
        bus.b        = 32'h0000_0001;
        bus.sub      = ALU_ADD;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ripple_accept in_ready=%b expected=1", bus.in_ready);
        end else begin
            sb.push_back(e);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL latency_early cycle=%0d out_valid=%b expected=0", i, bus.out_valid);
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency_due out_valid=%b expected=1", bus.out_valid);
        end
        @(posedge clk);
        #1;
        drain("ripple");
    endtask

    task automatic test_overflow_borrow();
        logic [31:0] ta [3];
        logic [31:0] tb [3];
        logic        ts [3];
        exp_t        te [3];
        int          w;
        ta[0] = 32'h7FFF_FFFF; tb[0] = 32'd1; ts[0] = ALU_ADD;
        te[0] = '{sum: 32'h8000_0000, c: 1'b0, ovf: 1'b1, zero: 1'b0};
        ta[1] = 32'h8000_0000; tb[1] = 32'd1; ts[1] = ALU_SUB;
        te[1] = '{sum: 32'h7FFF_FFFF, c: 1'b1, ovf: 1'b1, zero: 1'b0};
        ta[2] = 32'd3;         tb[2] = 32'd5; ts[2] = ALU_SUB;
        te[2] = '{sum: 32'hFFFF_FFFE, c: 1'b0, ovf: 1'b0, zero: 1'b0};
        for (int i = 0; i < 3; i++) send_beat(ta[i], tb[i], ts[i], te[i], w);
        drain("overflow_borrow");
    endtask

    task automatic test_back_to_back();
        logic [31:0] ra, rb;
        logic        rs;
        int          w, total, p0;
        total = 0;
        p0    = n_pop;
        for (int n = 0; n < 16; n++) begin
            ra = $urandom;
            rb = (n == 3) ? ra : $urandom;
            rs = (n == 3) ? 1'b1 : 1'($urandom_range(1, 0));
            send_beat(ra, rb, rs, model(ra, rb, rs), w);
            total += w;
        end
        checks++;
        if (total != 16) begin
            errors++;
            $display("FAIL back_to_back_cycles got=%0d expected=16", total);
        end
        drain("back_to_back");
        checks++;
        if (n_pop - p0 != 16) begin
            errors++;
            $display("FAIL back_to_back_count got=%0d expected=16", n_pop - p0);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0]  pat;
        logic [31:0] ra, rb;
        logic        rs;
        int          w, p0;
        bit          run;
        pat = 4'b1001;
        p0  = n_pop;
        run = 1'b1;
        fork
            begin
                for (int i = 0; run && i < 400; i++) begin
                    bus.out_ready = pat[i % 4];
                    @(posedge clk);
                    #1;
                end
            end
            begin
                for (int n = 0; n < 8; n++) begin
                    ra = $urandom;
                    rb = $urandom;
                    rs = 1'($urandom_range(1, 0));
                    send_beat(ra, rb, rs, model(ra, rb, rs), w);
                end
                drain("backpressure");
                run = 1'b0;
            end
        join
        bus.out_ready = 1'b1;
        checks++;
        if (n_pop - p0 != 8) begin
            errors++;
            $display("FAIL backpressure_count got=%0d expected=8", n_pop - p0);
        end
    endtask

    task automatic test_reset_mid();
        int   w, p0;
        exp_t e;
        bus.out_ready = 1'b0;
        send_beat(32'h1111_1111, 32'h2222_2222, ALU_ADD, model(32'h1111_1111, 32'h2222_2222, 1'b0), w);
        send_beat(32'h3333_3333, 32'h0000_0003, ALU_SUB, model(32'h3333_3333, 32'h0000_0003, 1'b1), w);
        send_beat(32'h4444_4444, 32'h5555_5555, ALU_ADD, model(32'h4444_4444, 32'h5555_5555, 1'b0), w);
        @(posedge clk);
        #2;
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_out_valid got=%b expected=1", bus.out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL async_reset out_valid,in_ready=%b expected=01",
                     {bus.out_valid, bus.in_ready});
        end
        checks++;
        if (bus.sum !== 32'd0) begin
            errors++;
            $display("FAIL async_reset_sum got=%h expected=0", bus.sum);
        end
        sb.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        p0 = n_pop;
        e  = '{sum: 32'h0000_00FF, c: 1'b0, ovf: 1'b0, zero: 1'b0};
        send_beat(32'h0000_00F0, 32'h0000_000F, ALU_ADD, e, w);
        drain("reset_mid");
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (n_pop - p0 != 1) begin
            errors++;
            $display("FAIL reset_mid_outputs got=%0d expected=1", n_pop - p0);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        mon_en = 1'b1;
        test_carry_ripple();
        test_overflow_borrow();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cla_adder_pipe.md
# cla_adder_pipe

Parametrised, pipelined carry-lookahead adder/subtractor for the datapath. It splits a WIDTH-bit operation into WIDTH/SLICE pipeline stages: each stage resolves one SLICE-bit group with 4-bit lookahead groups and registers the carry into the next stage. It adds a subtract mode, overflow/zero/carry flags and a valid/ready handshake with backpressure, so it can feed the ALU result path or a multi-cycle execute unit at full clock rate.

## Interface
- WIDTH, 32: operand and result width; must be a multiple of SLICE.
- SLICE, 8: bits resolved per pipeline stage; must be a multiple of 4. Latency is LAT = WIDTH/SLICE.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand beat present.
- in_ready  out  1  pipeline accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0 computes a+b; 1 computes a-b (a + ~b + 1).
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result this cycle.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- c_out  out  1  carry out of the MSB. In subtract mode, 1 means no borrow (a >= b unsigned).
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  out  1  sum == 0.

## Operation
- Global enable: en = !out_valid || out_ready. in_ready = en. The pipeline advances only when en=1; when en=0 every stage register holds.
- Accept: a beat enters stage 0 when in_valid && in_ready. The stage-0 valid bit loads in_valid on every en cycle, so bubbles propagate as invalid slots.
- Stage k (0..LAT-1) adds bits [k*SLICE +: SLICE] of a and b' (b' = sub ? ~b : b). The carry-in is sub for k=0, otherwise the registered carry from stage k-1.
- Stage k registers the following:
  - the completed low bits [0 .. (k+1)*SLICE-1];
  - the carry out;
  - for k=LAT-1, the carry into the MSB;
  - the untouched upper operand bits of a and b' (skew registers).
- The final stage registers sum, c_out, ovf and zero. These are held stable while out_valid && !out_ready.
- Bubbles are not compressed. Throughput is 1 beat/cycle when out_ready is held high.
- LAT=1 (SLICE=WIDTH) is legal and gives a single-register adder.

## Timing
- Reset (rst_n low, asynchronous): all valid bits 0; sum=0, c_out=0, ovf=0, zero=0; all intermediate data and carry registers 0; in_ready=1 while rst_n is low and after release.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+LAT-1 (visible in the cycle following edge N+LAT-1), provided no stall occurs.
- Stall: if out_valid=1 and out_ready=0, then in_ready=0 in the same cycle (combinational). No input is accepted and nothing is lost or duplicated.
- Simultaneous pop and push: with out_valid=1, out_ready=1 and in_valid=1, the output retires and the new beat enters in the same cycle.
- Reset mid-operation: all in-flight beats are discarded. out_valid drops to 0 immediately when rst_n is asserted (asynchronous).
- Wrap-around: sum wraps modulo 2^WIDTH. The carry/ovf flags carry the out-of-range information.

## Structure
- cla_pkg holds the following, so that the ALU decode can reuse them:
  - localparam LAT derivation helper;
  - the ALU_ADD/ALU_SUB encoding used to drive sub.
- Sub-module cla_slice: combinational SLICE-bit adder built from chained existing 4-bit lookahead groups. Ports: a, b, c_in, s, c_out, c_msb (carry into top bit).
- The top module instantiates LAT slices in a generate loop and owns all pipeline, skew and handshake registers.

## Test plan
All scenarios use WIDTH=32, SLICE=8, LAT=4.
- Reset and idle: hold rst_n=0 for 3 cycles, then release -> out_valid=0, in_ready=1, sum=0, all flags 0.
- Carry ripple across every slice: a=0xFFFFFFFF, b=0x00000001, sub=0 -> after 4 cycles sum=0, c_out=1, ovf=0, zero=1.
- Signed overflow in both modes:
  - a=0x7FFFFFFF, b=1, add -> sum=0x80000000, ovf=1, c_out=0.
  - a=0x80000000, b=1, sub -> sum=0x7FFFFFFF, ovf=1, c_out=1.
- Borrow: a=3, b=5, sub=1 -> sum=0xFFFFFFFE, c_out=0, ovf=0, zero=0.
- Backpressure: stream 8 random beats with out_ready toggling 1,0,0,1,…
  - Results match a scoreboard in order, with none dropped or duplicated.
  - in_ready==0 exactly while out_valid && !out_ready.
- Async reset mid-stream: assert rst_n low mid-cycle with 3 beats in flight -> out_valid=0 at once. After release, the first output is the first new beat only.
